rrf_dispatch_alloc: RTL and testbench
=====================================

RRF_DISPATCH_ALLOC -- requirements
Module: rrf_dispatch_alloc

Interface
REQ-001 SHALL have parameter RRF_NUM, default 64, meaning number of ROB/RRF entries.
REQ-002 SHALL have parameter RRF_SEL, default 6, meaning entry tag width.
REQ-003 SHALL have parameter REG_SEL, default 5, meaning architectural register index width.
REQ-004 SHALL have parameter INSN_LEN, default 32, meaning PC width.
REQ-005 SHALL have port clk_i  in  1  single clock; all state on rising edge.
REQ-006 SHALL have port reset_i  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port inst_valid_i  in  1  decoded instruction present.
REQ-008 SHALL have port pc_i  in  INSN_LEN  instruction PC.
REQ-009 SHALL have port dstvalid_i  in  1  instruction writes a destination.
REQ-010 SHALL have port dst_i  in  REG_SEL  destination register.
REQ-011 SHALL have port stall_i  in  1  downstream backpressure (reservation station full).
REQ-012 SHALL have port comnum_i  in  1  one entry committed by ROB this cycle.
REQ-013 SHALL have port inst_ready_o  out  1  instruction accepted when high with inst_valid_i.
REQ-014 SHALL have port dp1_o  out  1  dispatch strobe to ROB.
REQ-015 SHALL have port dp1_addr_o  out  RRF_SEL  allocated entry tag.
REQ-016 SHALL have port pc_dp1_o  out  INSN_LEN  dispatched PC.
REQ-017 SHALL have port dstvalid_dp1_o  out  1  dispatched dst-valid.
REQ-018 SHALL have port dst_dp1_o  out  REG_SEL  dispatched destination.
REQ-019 SHALL have port freenum_o  out  RRF_SEL+1  free entry count.
REQ-020 SHALL have port alloc_ptr_o  out  RRF_SEL  next tag to allocate.
REQ-021 SHALL have port wrap_o  out  1  toggles each time alloc_ptr wraps.

Function
REQ-022 SHALL drive inst_ready_o = (freenum_o != 0) & ~stall_i, combinationally.
REQ-023 SHALL define accept = inst_valid_i & inst_ready_o.
REQ-024 SHALL, on accept, register dp1_o=1, dp1_addr_o=alloc_ptr_o (pre-increment), pc/dstvalid/dst payload, visible the cycle after accept (latency 1).
REQ-025 SHALL register dp1_o=0 in any cycle without accept; payload outputs hold last value.
REQ-026 SHALL advance alloc_ptr_o by 1 modulo RRF_NUM per accept; 63 -> 0 toggles wrap_o.
REQ-027 SHALL update freenum_o: accept only -> -1; comnum_i only -> +1; both -> unchanged; neither -> unchanged.
REQ-028 SHALL never underflow freenum_o; accept is impossible at 0 per REQ-022.
REQ-029 SHALL saturate freenum_o at RRF_NUM if comnum_i arrives when already RRF_NUM (protocol violation; simulation assertion flags it).
REQ-030 SHALL accept with freenum_o==1 and comnum_i==1 in the same cycle, leaving freenum_o==1.
REQ-031 SHALL ignore pc_i/dst_i/dstvalid_i when no accept.

Reset
REQ-032 SHALL, on reset_i high, immediately (asynchronously) set dp1_o=0, dp1_addr_o=0, pc_dp1_o=0, dstvalid_dp1_o=0, dst_dp1_o=0, freenum_o=RRF_NUM, alloc_ptr_o=1, wrap_o=0.
REQ-033 SHALL reset alloc_ptr_o to 1 so the first tag matches the ROB commit pointer reset value of 1.
REQ-034 SHALL discard any accept in the cycle reset asserts; a registered dp1_o pending is cleared.
REQ-035 SHALL hold inst_ready_o per REQ-022 after reset (high when ~stall_i).

Verification
REQ-036 SHALL cover: reset, then valid for 3 cycles, stall_i=0 -> dp1_o high cycles 2-4 with tags 1,2,3; freenum_o 64->61.
REQ-037 SHALL cover: 64 back-to-back accepts, no commits -> freenum_o=0, inst_ready_o=0, tags 1..63,0, wrap_o=1 after tag 63.
REQ-038 SHALL cover: freenum_o=0, comnum_i=1 one cycle -> freenum_o=1, next valid accepted with tag 1.
REQ-039 SHALL cover: accept and comnum_i same cycle at freenum_o=10 -> freenum_o stays 10, alloc_ptr_o +1.
REQ-040 SHALL cover: stall_i=1 with inst_valid_i=1 -> inst_ready_o=0, dp1_o=0, counters unchanged.
REQ-041 SHALL cover: reset_i asserted mid-burst between clock edges -> outputs at reset values before next edge.

Source files
------------

// File: rtl/rrf_dispatch_alloc.sv
// rtl/rrf_dispatch_alloc.sv - dispatch-stage RRF/ROB tag allocator with free-entry accounting
module rrf_dispatch_alloc #(
  parameter int RRF_NUM  = 64,
  parameter int RRF_SEL  = 6,
  parameter int REG_SEL  = 5,
  parameter int INSN_LEN = 32
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                inst_valid_i,
  input  logic [INSN_LEN-1:0] pc_i,
  input  logic                dstvalid_i,
  input  logic [REG_SEL-1:0]  dst_i,
  input  logic                stall_i,
  input  logic                comnum_i,
  output logic                inst_ready_o,
  output logic                dp1_o,
  output logic [RRF_SEL-1:0]  dp1_addr_o,
  output logic [INSN_LEN-1:0] pc_dp1_o,
  output logic                dstvalid_dp1_o,
  output logic [REG_SEL-1:0]  dst_dp1_o,
  output logic [RRF_SEL:0]    freenum_o,
  output logic [RRF_SEL-1:0]  alloc_ptr_o,
  output logic                wrap_o
);

  localparam logic [RRF_SEL:0]   LP_FULL = (RRF_SEL+1)'(RRF_NUM);
  localparam logic [RRF_SEL-1:0] LP_LAST = RRF_SEL'(RRF_NUM - 1);

  logic                r_dp1;
  logic [RRF_SEL-1:0]  r_dp1_addr;
  logic [INSN_LEN-1:0] r_pc_dp1;
  logic                r_dstvalid_dp1;
  logic [REG_SEL-1:0]  r_dst_dp1;
  logic [RRF_SEL:0]    r_freenum;
  logic [RRF_SEL-1:0]  r_alloc_ptr;
  logic                r_wrap;

  logic w_ready;
  logic w_accept;
  logic w_ptr_last;

  assign w_ready    = (r_freenum != '0) & ~stall_i;
  assign w_accept   = inst_valid_i & w_ready;
  assign w_ptr_last = (r_alloc_ptr == LP_LAST);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_dp1          <= 1'b0;
      r_dp1_addr     <= '0;
      r_pc_dp1       <= '0;
      r_dstvalid_dp1 <= 1'b0;
      r_dst_dp1      <= '0;
      r_freenum      <= LP_FULL;
      // First tag is 1 to line up with the ROB commit pointer's reset value.
      r_alloc_ptr    <= RRF_SEL'(1);
      r_wrap         <= 1'b0;
    end else begin
      r_dp1 <= w_accept;
      if (w_accept) begin
        r_dp1_addr     <= r_alloc_ptr;
        r_pc_dp1       <= pc_i;
        r_dstvalid_dp1 <= dstvalid_i;
        r_dst_dp1      <= dst_i;
        r_alloc_ptr    <= w_ptr_last ? '0 : r_alloc_ptr + RRF_SEL'(1);
        if (w_ptr_last) r_wrap <= ~r_wrap;
      end
      case ({w_accept, comnum_i})
        2'b10:   r_freenum <= r_freenum - 1'b1;
        2'b01:   r_freenum <= (r_freenum == LP_FULL) ? LP_FULL : r_freenum + 1'b1;
        default: r_freenum <= r_freenum;
      endcase
    end
  end

  // A commit with every entry already free means the ROB and allocator disagree.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(comnum_i && !w_accept && r_freenum == LP_FULL))
        else $error("rrf_dispatch_alloc: commit while all entries free");
    end
  end

  assign inst_ready_o   = w_ready;
  assign dp1_o          = r_dp1;
  assign dp1_addr_o     = r_dp1_addr;
  assign pc_dp1_o       = r_pc_dp1;
  assign dstvalid_dp1_o = r_dstvalid_dp1;
  assign dst_dp1_o      = r_dst_dp1;
  assign freenum_o      = r_freenum;
  assign alloc_ptr_o    = r_alloc_ptr;
  assign wrap_o         = r_wrap;

endmodule

// File: tb/tb_rrf_dispatch_alloc.sv
// tb/tb_rrf_dispatch_alloc.sv - directed self-checking bench for rrf_dispatch_alloc
module tb_rrf_dispatch_alloc;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        inst_valid_i;
  logic [31:0] pc_i;
  logic        dstvalid_i;
  logic [4:0]  dst_i;
  logic        stall_i;
  logic        comnum_i;
  logic        inst_ready_o;
  logic        dp1_o;
  logic [5:0]  dp1_addr_o;
  logic [31:0] pc_dp1_o;
  logic        dstvalid_dp1_o;
  logic [4:0]  dst_dp1_o;
  logic [6:0]  freenum_o;
  logic [5:0]  alloc_ptr_o;
  logic        wrap_o;

  int checks   = 0;
  int failures = 0;

  rrf_dispatch_alloc dut (
    .clk_i(clk_i), .reset_i(reset_i), .inst_valid_i(inst_valid_i), .pc_i(pc_i),
    .dstvalid_i(dstvalid_i), .dst_i(dst_i), .stall_i(stall_i), .comnum_i(comnum_i),
    .inst_ready_o(inst_ready_o), .dp1_o(dp1_o), .dp1_addr_o(dp1_addr_o),
    .pc_dp1_o(pc_dp1_o), .dstvalid_dp1_o(dstvalid_dp1_o), .dst_dp1_o(dst_dp1_o),
    .freenum_o(freenum_o), .alloc_ptr_o(alloc_ptr_o), .wrap_o(wrap_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_dp1"}, 64'(dp1_o), 64'd0);
    chk({tag, "_addr"}, 64'(dp1_addr_o), 64'd0);
    chk({tag, "_pc"}, 64'(pc_dp1_o), 64'd0);
    chk({tag, "_dstv"}, 64'(dstvalid_dp1_o), 64'd0);
    chk({tag, "_dst"}, 64'(dst_dp1_o), 64'd0);
    chk({tag, "_free"}, 64'(freenum_o), 64'd64);
    chk({tag, "_ptr"}, 64'(alloc_ptr_o), 64'd1);
    chk({tag, "_wrap"}, 64'(wrap_o), 64'd0);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    step();
    step();
    reset_i = 1'b0;
    #1;
  endtask

  initial begin
    reset_i = 1'b1; inst_valid_i = 1'b0; pc_i = '0; dstvalid_i = 1'b0;
    dst_i = '0; stall_i = 1'b0; comnum_i = 1'b0;
    #2;
    chk_reset_state("async_rst");
    do_reset();
    chk_reset_state("post_rst");
    chk("post_rst_ready", 64'(inst_ready_o), 64'd1);

    // three accepts: tags 1,2,3, free 64->61
    for (int i = 0; i < 3; i++) begin
      inst_valid_i = 1'b1; pc_i = 32'h1000 + 32'(4 * i);
      dstvalid_i = i[0]; dst_i = 5'(i + 3);
      step();
      chk($sformatf("burst3_dp1_%0d", i), 64'(dp1_o), 64'd1);
      chk($sformatf("burst3_tag_%0d", i), 64'(dp1_addr_o), 64'(i + 1));
      chk($sformatf("burst3_pc_%0d", i), 64'(pc_dp1_o), 64'(32'h1000 + 4 * i));
      chk($sformatf("burst3_dstv_%0d", i), 64'(dstvalid_dp1_o), 64'(i % 2));
      chk($sformatf("burst3_dst_%0d", i), 64'(dst_dp1_o), 64'(i + 3));
    end
    chk("burst3_free", 64'(freenum_o), 64'd61);
    chk("burst3_ptr", 64'(alloc_ptr_o), 64'd4);

    // idle: dp1 drops, payload holds, other inputs ignored
    inst_valid_i = 1'b0; pc_i = 32'hdead_beef; dst_i = 5'd31; dstvalid_i = 1'b0;
    step();
    chk("idle_dp1", 64'(dp1_o), 64'd0);
    chk("idle_pc_hold", 64'(pc_dp1_o), 64'h1008);
    chk("idle_dst_hold", 64'(dst_dp1_o), 64'd5);
    chk("idle_addr_hold", 64'(dp1_addr_o), 64'd3);

    // stall blocks acceptance
    stall_i = 1'b1; inst_valid_i = 1'b1;
    #1;
    chk("stall_ready", 64'(inst_ready_o), 64'd0);
    step();
    chk("stall_dp1", 64'(dp1_o), 64'd0);
    chk("stall_free", 64'(freenum_o), 64'd61);
    chk("stall_ptr", 64'(alloc_ptr_o), 64'd4);
    stall_i = 1'b0;

    // 51 more accepts to reach free=10, ptr=55
    for (int i = 0; i < 51; i++) begin
      pc_i = 32'(i);
      step();
    end
    chk("to10_free", 64'(freenum_o), 64'd10);
    chk("to10_ptr", 64'(alloc_ptr_o), 64'd55);
    chk("to10_last_tag", 64'(dp1_addr_o), 64'd54);

    // accept and commit together
    comnum_i = 1'b1;
    step();
    comnum_i = 1'b0; inst_valid_i = 1'b0;
    chk("acc_com_free", 64'(freenum_o), 64'd10);
    chk("acc_com_ptr", 64'(alloc_ptr_o), 64'd56);
    chk("acc_com_tag", 64'(dp1_addr_o), 64'd55);

    // commit only: +1
    comnum_i = 1'b1;
    step();
    comnum_i = 1'b0;
    chk("com_only_free", 64'(freenum_o), 64'd11);
    chk("com_only_dp1", 64'(dp1_o), 64'd0);

    // full ring from reset: tags 1..63,0
    do_reset();
    inst_valid_i = 1'b1;
    for (int i = 0; i < 64; i++) begin
      pc_i = 32'h2000 + 32'(i);
      step();
      chk($sformatf("ring_tag_%0d", i), 64'(dp1_addr_o), 64'((i + 1) % 64));
      if (i == 62) chk("ring_wrap_after63", 64'(wrap_o), 64'd1);
      if (i == 61) chk("ring_wrap_before63", 64'(wrap_o), 64'd0);
    end
    chk("ring_free0", 64'(freenum_o), 64'd0);
    chk("ring_ready0", 64'(inst_ready_o), 64'd0);
    chk("ring_ptr", 64'(alloc_ptr_o), 64'd1);
    step();
    chk("full_no_dp1", 64'(dp1_o), 64'd0);
    chk("full_free_hold", 64'(freenum_o), 64'd0);

    // one commit frees one entry, next accept gets tag 1
    inst_valid_i = 1'b0; comnum_i = 1'b1;
    step();
    comnum_i = 1'b0;
    chk("commit_free1", 64'(freenum_o), 64'd1);
    chk("commit_ready", 64'(inst_ready_o), 64'd1);
    inst_valid_i = 1'b1; pc_i = 32'h3000;
    step();
    inst_valid_i = 1'b0;
    chk("refill_dp1", 64'(dp1_o), 64'd1);
    chk("refill_tag", 64'(dp1_addr_o), 64'd1);
    chk("refill_pc", 64'(pc_dp1_o), 64'h3000);
    chk("refill_free0", 64'(freenum_o), 64'd0);

    // free=1 with accept and commit together stays 1
    comnum_i = 1'b1;
    step();
    inst_valid_i = 1'b1;
    chk("edge1_free", 64'(freenum_o), 64'd1);
    step();
    comnum_i = 1'b0; inst_valid_i = 1'b0;
    chk("edge1_acc_com_free", 64'(freenum_o), 64'd1);
    chk("edge1_tag", 64'(dp1_addr_o), 64'd2);
    chk("edge1_dp1", 64'(dp1_o), 64'd1);

    // asynchronous reset mid-burst
    do_reset();
    inst_valid_i = 1'b1; dstvalid_i = 1'b1; dst_i = 5'd9; pc_i = 32'h4444;
    step();
    step();
    chk("midburst_dp1_pre", 64'(dp1_o), 64'd1);
    #2;
    reset_i = 1'b1;
    #1;
    chk_reset_state("midburst_rst");
    step();
    chk_reset_state("midburst_rst_held");
    reset_i = 1'b0; inst_valid_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
